prog_loader: RTL
================

Name: prog_loader

Overview:
Boot-time program loader that sits directly upstream of the CPU datapath's instruction memory. It receives a framed byte stream, assembles 32-bit little-endian instruction words and writes them sequentially into the program memory write port. It verifies an XOR checksum, then releases the CPU through cpuRunEn. Until cpuRunEn rises, the datapath's sysClk-domain logic is held idle.

Parameters:
ADDR_W, 10, program memory address width in words
MEM_DEPTH, 1024, maximum loadable words; must be <= 2^ADDR_W
TIMEOUT, 4096, max idle cycles between accepted bytes before abort; 0 disables

Ports:
sysClk  in  1  system clock; all state updates on rising edge
sysRst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
byteIn  in  8  stream data byte
byteValid  in  1  byteIn is valid
byteReady  out  1  loader can accept a byte this cycle
pmWrEn  out  1  program memory write strobe, one cycle per word
pmWrAddr  out  ADDR_W  word address for the write
pmWrData  out  32  assembled instruction word
cpuRunEn  out  1  high = CPU may run; level output
loadDone  out  1  high in DONE
loadErr  out  1  high in ERR
errCode  out  2  00 none, 01 size, 10 checksum, 11 timeout
wordsLoaded  out  ADDR_W+1  count of words written in the current load

Behaviour:
- Reset: asynchronous. All outputs go to 0 and state goes to IDLE. Reset mid-load abandons the load; memory contents already written are left as they are.
- A byte is accepted on a rising edge where byteValid && byteReady. byteReady = 1 only in HDR, DATA and CSUM. byteReady is registered and does not depend on byteValid.
- States and transitions:
  - IDLE: on start go to HDR; clear byte index, word count, checksum, wordsLoaded, errCode and idle timer; drive cpuRunEn = 0.
  - HDR: accept 4 bytes (LSB first) as word count N.
    - On the 4th byte, if N > MEM_DEPTH: go to ERR with errCode = 01.
    - If N == 0: go to CSUM.
    - Otherwise go to DATA.
  - DATA: accept bytes LSB first into a 32-bit shift/assemble register.
    - On each 4th byte, in the next cycle: pmWrEn = 1, pmWrAddr = wordsLoaded[ADDR_W-1:0], pmWrData = assembled word; wordsLoaded increments in that same cycle.
    - The write cycle overlaps acceptance of the next byte; there are no bubbles.
    - After word N is accepted, go to CSUM. Its write still issues in the following cycle.
  - CSUM: accept 1 byte.
    - If it equals the running XOR of all header and data bytes: go to DONE.
    - Otherwise go to ERR with errCode = 10.
  - DONE: loadDone = 1 and cpuRunEn = 1, both one cycle after the checksum byte is accepted.
  - ERR: loadErr = 1, cpuRunEn = 0, byteReady = 0.
- The checksum is the XOR of every accepted byte from the first header byte through the last data byte.
- Timeout:
  - In HDR, DATA and CSUM, an idle counter increments each cycle without an accepted byte and clears on acceptance.
  - When it reaches TIMEOUT, go to ERR with errCode = 11.
  - When TIMEOUT = 0 the counter is inert.
- start while in HDR, DATA or CSUM is ignored.
- start in DONE or ERR restarts the load: go to HDR, clear the outputs as in IDLE, and drop cpuRunEn in the next cycle.
- pmWrEn is never asserted outside DATA, except for the single trailing write of word N. At most N writes occur per load.
- pmWrAddr and pmWrData hold their last values when pmWrEn = 0.

Test Plan:
- Normal load: start; stream 02 00 00 00, 44 33 22 11, DD CC BB AA, checksum 46. Required: writes (0, 0x11223344) and (1, 0xAABBCCDD); wordsLoaded = 2; loadDone = cpuRunEn = 1; errCode = 00.
- Empty program: stream 00 00 00 00, then 00. Required: no pmWrEn; DONE; cpuRunEn = 1.
- Bad checksum: same as the normal load but with checksum 47. Required: both words written; ERR; errCode = 10; cpuRunEn = 0; byteReady = 0.
- Oversize: header 01 04 00 00 (N = 1025 > 1024). Required: ERR after the 4th byte; errCode = 01; zero writes.
- Timeout (TIMEOUT = 16): stall byteValid for 16 cycles after the 2nd header byte. Required: ERR; errCode = 11. Then start and a valid stream gives DONE.
- Throttling and reset: toggle byteValid randomly during the normal load. Required: identical writes and DONE. Assert sysRst_n = 0 mid-DATA. Required: outputs go to 0 immediately and the state is IDLE.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader in front of the CPU instruction memory.
// Receives a framed byte stream (4-byte LE word count, N LE data words,
// 1 XOR checksum byte), writes words sequentially to the program memory and
// releases the CPU via cpuRunEn once the checksum matches.
// Ports:
//   sysClk, sysRst_n        clock, async active-low reset
//   start                   pulse; begins a load from IDLE/DONE/ERR
//   byteIn/byteValid/byteReady  byte stream handshake (byteReady registered)
//   pmWrEn/pmWrAddr/pmWrData    program memory write port
//   cpuRunEn, loadDone, loadErr, errCode, wordsLoaded  status
module prog_loader #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned MEM_DEPTH = 1024,
   parameter int unsigned TIMEOUT   = 4096
) (
   input  logic              sysClk,
   input  logic              sysRst_n,
   input  logic              start,
   input  logic [7:0]        byteIn,
   input  logic              byteValid,
   output logic              byteReady,
   output logic              pmWrEn,
   output logic [ADDR_W-1:0] pmWrAddr,
   output logic [31:0]       pmWrData,
   output logic              cpuRunEn,
   output logic              loadDone,
   output logic              loadErr,
   output logic [1:0]        errCode,
   output logic [ADDR_W:0]   wordsLoaded
);

   // Idle counter only needs to reach TIMEOUT-1 before the abort fires.
   localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [31:0]       asm_q, asm_d;
   logic [31:0]       count_q, count_d;
   logic [7:0]        csum_q, csum_d;
   logic [ADDR_W:0]   words_q, words_d;
   logic [1:0]        err_q, err_d;
   logic [TMR_W-1:0]  idle_q, idle_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic              ready_q, ready_d;
   logic              run_q, run_d;
   logic              done_q, done_d;
   logic              lerr_q, lerr_d;

   logic              accept;
   logic              active;
   logic [31:0]       word_next;

   assign accept    = byteValid && ready_q;
   assign active    = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
   assign word_next = {byteIn, asm_q[31:8]};

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      asm_d      = asm_q;
      count_d    = count_q;
      csum_d     = csum_q;
      words_d    = words_q;
      err_d      = err_q;
      idle_d     = idle_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      // wordsLoaded advances at the end of the write cycle, so pmWrAddr
      // equals wordsLoaded while pmWrEn is high.
      if (wr_en_q) words_d = words_q + (ADDR_W+1)'(1);

      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d    = S_HDR;
               byte_idx_d = '0;
               words_d    = '0;
               csum_d     = '0;
               err_d      = 2'b00;
               idle_d     = '0;
            end
         end
         S_HDR: begin
            if (accept) begin
               asm_d      = word_next;
               csum_d     = csum_q ^ byteIn;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  count_d = word_next;
                  if (word_next > MEM_DEPTH) begin
                     state_d = S_ERR;
                     err_d   = 2'b01;
                  end else if (word_next == '0) begin
                     state_d = S_CSUM;
                  end else begin
                     state_d = S_DATA;
                  end
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               asm_d      = word_next;
               csum_d     = csum_q ^ byteIn;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = words_q[ADDR_W-1:0];
                  wr_data_d = word_next;
                  // The previous word's write has always retired by now, so
                  // words_q counts every word before this one.
                  if (32'(words_q) + 32'd1 == count_q) state_d = S_CSUM;
               end
            end
         end
         S_CSUM: begin
            if (accept) begin
               if (byteIn == csum_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_ERR;
                  err_d   = 2'b10;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Idle timer; an accepted byte is the only way out of an active state,
      // so this never competes with a transition made above.
      if (TIMEOUT != 0 && active) begin
         if (accept) begin
            idle_d = '0;
         end else if (32'(idle_q) == TIMEOUT - 32'd1) begin
            state_d = S_ERR;
            err_d   = 2'b11;
         end else begin
            idle_d = idle_q + TMR_W'(1);
         end
      end

      ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
      run_d   = (state_d == S_DONE);
      done_d  = (state_d == S_DONE);
      lerr_d  = (state_d == S_ERR);
   end

   always_ff @(posedge sysClk or negedge sysRst_n) begin
      if (!sysRst_n) begin
         state_q    <= S_IDLE;
         byte_idx_q <= '0;
         asm_q      <= '0;
         count_q    <= '0;
         csum_q     <= '0;
         words_q    <= '0;
         err_q      <= '0;
         idle_q     <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         ready_q    <= 1'b0;
         run_q      <= 1'b0;
         done_q     <= 1'b0;
         lerr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         asm_q      <= asm_d;
         count_q    <= count_d;
         csum_q     <= csum_d;
         words_q    <= words_d;
         err_q      <= err_d;
         idle_q     <= idle_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         ready_q    <= ready_d;
         run_q      <= run_d;
         done_q     <= done_d;
         lerr_q     <= lerr_d;
      end
   end

   assign byteReady   = ready_q;
   assign pmWrEn      = wr_en_q;
   assign pmWrAddr    = wr_addr_q;
   assign pmWrData    = wr_data_q;
   assign cpuRunEn    = run_q;
   assign loadDone    = done_q;
   assign loadErr     = lerr_q;
   assign errCode     = err_q;
   assign wordsLoaded = words_q;

endmodule
